// File: rtl/button_conditioner_pkg.sv
// Shared types and button bit indices for the push-button conditioning path.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_C = 4;

endpackage

// File: rtl/button_conditioner_btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, debounce FSM and auto-repeat timer.
module btn_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic press_next_o
);
  import button_conditioner_pkg::*;

  localparam int unsigned DebW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RepMax  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW    = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam bit          RepeatEn = (REPEAT_DELAY > 0);
  localparam int unsigned DelayM1 = RepeatEn ? REPEAT_DELAY - 1 : 0;
  localparam int unsigned RateM1  = (REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0;

  localparam logic [DebW-1:0] DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast = RepW'(DelayM1);
  localparam logic [RepW-1:0] RateLast  = RepW'(RateM1);

  logic            s1_q, s2_q;
  btn_state_t      state_q, state_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            first_rep_q, first_rep_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    first_rep_d = first_rep_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DebLast) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          level_d     = 1'b1;
          rep_cnt_d   = '0;
          first_rep_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end else if (RepeatEn) begin
          if (first_rep_q && (rep_cnt_q == DelayLast)) begin
            repeat_d    = 1'b1;
            rep_cnt_d   = '0;
            first_rep_d = 1'b0;
          end else if (!first_rep_q && (rep_cnt_q == RateLast)) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high resumes the hold; the repeat phase is kept.
        if (s2_q) begin
          state_d   = PRESSED;
          rep_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      first_rep_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      s1_q        <= raw_i;
      s2_q        <= s1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      first_rep_q <= first_rep_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign repeat_o     = repeat_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw push-buttons into clean level/press/release/repeat signals on ClkPort.
module button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic             ClkPort,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);
  import button_conditioner_pkg::*;

  logic [N_BTN-1:0] press_next;
  logic             any_press_q, any_press_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk_i       (ClkPort),
      .rst_i       (Reset),
      .raw_i       (btn_raw[i]),
      .level_o     (btn_level[i]),
      .press_o     (btn_press[i]),
      .release_o   (btn_release[i]),
      .repeat_o    (btn_repeat[i]),
      .press_next_o(press_next[i])
    );
  end

  // Registered from the channels' next-state press so it lines up with btn_press.
  always_comb begin
    any_press_d = |press_next;
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios plus random bouncing against a behavioural model.
module tb_button_conditioner;
  localparam int NB   = 5;
  localparam int DEB  = 8;
  localparam int DLY  = 20;
  localparam int RATE = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] level, press, rel, rep;
  logic          anyp;

  button_conditioner #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_RATE    (RATE)
  ) dut (
    .ClkPort    (clk),
    .Reset      (rst),
    .btn_raw    (raw),
    .btn_level  (level),
    .btn_press  (press),
    .btn_release(rel),
    .btn_repeat (rep),
    .any_press  (anyp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: accepted level flips once the synchronized input has disagreed for DEB+1 edges.
  bit            m_d1[NB], m_d2[NB], m_lv[NB], m_first[NB];
  int            m_run[NB], m_t[NB];
  logic [NB-1:0] e_lv, e_pr, e_rl, e_rp;
  logic          e_any;

  wire [4*NB:0] dut_v = {level, press, rel, rep, anyp};
  wire [4*NB:0] exp_v = {e_lv, e_pr, e_rl, e_rp, e_any};

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_d1[i] = 0; m_d2[i] = 0; m_lv[i] = 0; m_first[i] = 0; m_run[i] = 0; m_t[i] = 0;
    end
    e_lv = '0; e_pr = '0; e_rl = '0; e_rp = '0; e_any = 1'b0;
  endtask

  task automatic model_step(input logic [NB-1:0] r);
    for (int i = 0; i < NB; i++) begin
      bit sv;
      int prev;
      e_pr[i] = 1'b0; e_rl[i] = 1'b0; e_rp[i] = 1'b0;
      sv = m_d2[i]; m_d2[i] = m_d1[i]; m_d1[i] = r[i];
      prev = m_run[i];
      if (sv != m_lv[i]) m_run[i]++; else m_run[i] = 0;
      if (m_run[i] == DEB + 1) begin
        m_lv[i] = !m_lv[i];
        m_run[i] = 0;
        if (m_lv[i]) begin
          e_pr[i] = 1'b1; m_t[i] = 0; m_first[i] = 1;
        end else begin
          e_rl[i] = 1'b1;
        end
      end else if (m_lv[i] && sv) begin
        if (prev > 0) begin
          m_t[i] = 0;
        end else begin
          m_t[i]++;
          if (m_t[i] == (m_first[i] ? DLY : RATE)) begin
            e_rp[i] = 1'b1; m_t[i] = 0; m_first[i] = 0;
          end
        end
      end
      e_lv[i] = m_lv[i];
    end
    e_any = |e_pr;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) model_step(raw);
    else model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw = '0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (dut_v !== '0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h exp=0", cyc, dut_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int pk = 0, np = 0;
    raw[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL clean_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
      if (press[0]) begin np++; if (pk == 0) pk = k; end
    end
    total++;
    if (pk !== DEB + 3 || np !== 1) begin
      bad++;
      $display("FAIL clean_latency got edge=%0d count=%0d exp edge=%0d count=1", pk, np, DEB + 3);
    end
    total++;
    if (level[0] !== 1'b1) begin
      bad++;
      $display("FAIL clean_level got=%b exp=1", level[0]);
    end
    raw[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL clean_rel_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_bounce_reject();
    int seen = 0;
    for (int k = 1; k <= 20; k++) begin
      raw[2] = (k <= 5);
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
      if (press[2] || level[2]) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL bounce_reject got=%0d press/level cycles exp=0", seen);
    end
  endtask

  task automatic test_bouncy_press();
    int pk = 0, np = 0;
    for (int k = 1; k <= 30; k++) begin
      raw[0] = (k == 1 || k == 3 || k >= 5);
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL bouncy_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
      if (press[0]) begin np++; if (pk == 0) pk = k; end
    end
    total++;
    if (pk !== 5 + DEB + 2 || np !== 1) begin
      bad++;
      $display("FAIL bouncy_press got edge=%0d count=%0d exp edge=%0d count=1", pk, np, 5 + DEB + 2);
    end
    raw[0] = 1'b0;
    for (int k = 0; k < 20; k++) tick();
  endtask

  task automatic test_auto_repeat();
    int first = 0, nrep = 0, rk = 0, late = 0;
    int exp_first = DEB + 3 + DLY;
    int exp_n = (60 + 2 - exp_first) / RATE + 1;
    for (int k = 1; k <= 80; k++) begin
      raw[1] = (k <= 60);
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL repeat_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
      if (rep[1]) begin
        nrep++;
        if (first == 0) first = k;
        if (rk != 0) late++;
      end
      if (rel[1]) rk = k;
    end
    total++;
    if (first !== exp_first || nrep !== exp_n) begin
      bad++;
      $display("FAIL repeat_timing got first=%0d n=%0d exp first=%0d n=%0d",
               first, nrep, exp_first, exp_n);
    end
    total++;
    if (rk !== 60 + DEB + 3 || late !== 0) begin
      bad++;
      $display("FAIL repeat_release got edge=%0d late=%0d exp edge=%0d late=0",
               rk, late, 60 + DEB + 3);
    end
  endtask

  task automatic test_simultaneous();
    int both = 0, other = 0;
    raw[4:3] = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL simul_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
      if (press[3] && press[4]) both++;
      if (press[3] != press[4] || press[2:0] != '0) other++;
    end
    total++;
    if (both !== 1 || other !== 0) begin
      bad++;
      $display("FAIL simultaneous got both=%0d other=%0d exp both=1 other=0", both, other);
    end
    raw[4:3] = 2'b00;
    for (int k = 0; k < 20; k++) tick();
  endtask

  task automatic test_reset_mid_hold();
    int pk = 0, nrel = 0;
    raw[0] = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    total++;
    if (level[0] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre_level got=%b exp=1", level[0]);
    end
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (dut_v !== '0) begin
      bad++;
      $display("FAIL midrst_async got=%h exp=0", dut_v);
    end
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL midrst_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
      if (press[0] && pk == 0) pk = k;
      if (rel[0]) nrel++;
    end
    total++;
    if (pk !== DEB + 3 || nrel !== 0) begin
      bad++;
      $display("FAIL midrst_repress got edge=%0d rel=%0d exp edge=%0d rel=0", pk, nrel, DEB + 3);
    end
    raw[0] = 1'b0;
    for (int k = 0; k < 20; k++) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, (k < 2000) ? 15 : 63) == 0) raw[i] = !raw[i];
      end
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_bouncy_press();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
